// File: rtl/mem_arb_pkg.sv
// Shared state encoding and counter sizing for the unified memory port arbiter.
package mem_arb_pkg;

   localparam int STARVE_CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      IBUSY = 2'd1,
      DBUSY = 2'd2
   } arbState_t;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of data grants that overtook a waiting fetch; 1-cycle update.
// atMax tells the arbiter that fetch must win the next contested slot.
module mem_arb_starve_ctr
   import mem_arb_pkg::*;
#(
   parameter int MAX = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic atMax
);

   localparam logic [STARVE_CNT_W-1:0] MAX_CNT = STARVE_CNT_W'(MAX);

   logic [STARVE_CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && !atMax) begin
         cnt <= cnt + STARVE_CNT_W'(1);
      end
   end

   assign atMax = (cnt >= MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and data stages; request to mem_req is 1 cycle, ack to Rdy is 1 cycle.
// Requesters are stalled until their Rdy pulse; the memory throttles us only through mem_ack.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          IReqF,
   input  logic [AW-1:0] PCF,
   output logic [DW-1:0] InstrF,
   output logic          IRdyF,
   output logic          StallF,
   input  logic          DReqM,
   input  logic          MemWriteM,
   input  logic [AW-1:0] DataAdrM,
   input  logic [DW-1:0] WriteDataM,
   output logic [DW-1:0] ReadDataM,
   output logic          DRdyM,
   output logic          StallM,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ack
);

   arbState_t     state, stateNext;
   logic          memReqNext, memWeNext, iRdyNext, dRdyNext;
   logic [AW-1:0] memAddrNext;
   logic [DW-1:0] memWdataNext, instrNext, readDataNext;
   logic          fetchElig, dataElig, dataWin;
   logic          starveInc, starveClr, starveAtMax;

   // A requester whose Rdy is high is retiring this cycle, so its held request is stale.
   assign fetchElig = IReqF & ~IRdyF;
   assign dataElig  = DReqM & ~DRdyM;
   assign dataWin   = dataElig & (~fetchElig | ~starveAtMax);

   assign StallF = IReqF & ~IRdyF;
   assign StallM = DReqM & ~DRdyM;

   mem_arb_starve_ctr #(
      .MAX(STARVE_MAX)
   ) u_starve (
      .clk  (clk),
      .reset(reset),
      .inc  (starveInc),
      .clr  (starveClr),
      .atMax(starveAtMax)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         IRdyF     <= 1'b0;
         DRdyM     <= 1'b0;
         InstrF    <= '0;
         ReadDataM <= '0;
      end else begin
         state     <= stateNext;
         mem_req   <= memReqNext;
         mem_we    <= memWeNext;
         mem_addr  <= memAddrNext;
         mem_wdata <= memWdataNext;
         IRdyF     <= iRdyNext;
         DRdyM     <= dRdyNext;
         InstrF    <= instrNext;
         ReadDataM <= readDataNext;
      end
   end

   always_comb begin
      stateNext    = state;
      memReqNext   = mem_req;
      memWeNext    = mem_we;
      memAddrNext  = mem_addr;
      memWdataNext = mem_wdata;
      iRdyNext     = 1'b0;
      dRdyNext     = 1'b0;
      instrNext    = InstrF;
      readDataNext = ReadDataM;
      starveInc    = 1'b0;
      starveClr    = 1'b0;

      case (state)
         IDLE: begin
            if (dataWin) begin
               stateNext    = DBUSY;
               memReqNext   = 1'b1;
               memWeNext    = MemWriteM;
               memAddrNext  = DataAdrM;
               memWdataNext = WriteDataM;
               starveInc    = fetchElig;
            end else if (fetchElig) begin
               stateNext   = IBUSY;
               memReqNext  = 1'b1;
               memWeNext   = 1'b0;
               memAddrNext = PCF;
               starveClr   = 1'b1;
            end
         end
         IBUSY: begin
            if (mem_ack) begin
               stateNext  = IDLE;
               memReqNext = 1'b0;
               memWeNext  = 1'b0;
               iRdyNext   = 1'b1;
               instrNext  = mem_rdata;
            end
         end
         DBUSY: begin
            if (mem_ack) begin
               stateNext  = IDLE;
               memReqNext = 1'b0;
               memWeNext  = 1'b0;
               dRdyNext   = 1'b1;
               // Use the latched write flag; the live MemWriteM may already belong to the next request.
               if (!mem_we) begin
                  readDataNext = mem_rdata;
               end
            end
         end
         default: begin
            stateNext  = IDLE;
            memReqNext = 1'b0;
            memWeNext  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: transaction-level model of arbitration, memory and stage handshakes.
module tb_mem_port_arbiter;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int SMAX = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          IReqF;
   logic [AW-1:0] PCF;
   logic [DW-1:0] InstrF;
   logic          IRdyF, StallF;
   logic          DReqM, MemWriteM;
   logic [AW-1:0] DataAdrM;
   logic [DW-1:0] WriteDataM, ReadDataM;
   logic          DRdyM, StallM;
   logic          mem_req, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          mem_ack;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .AW(AW), .DW(DW), .STARVE_MAX(SMAX)
   ) dut (
      .clk(clk), .reset(reset),
      .IReqF(IReqF), .PCF(PCF), .InstrF(InstrF), .IRdyF(IRdyF), .StallF(StallF),
      .DReqM(DReqM), .MemWriteM(MemWriteM), .DataAdrM(DataAdrM), .WriteDataM(WriteDataM),
      .ReadDataM(ReadDataM), .DRdyM(DRdyM), .StallM(StallM),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   int chkCnt = 0;
   int errCnt = 0;

   task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      chkCnt++;
      if (obs !== exp) begin
         errCnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Behavioural memory: written by stores, otherwise a fixed address-derived pattern.
   logic [DW-1:0] memArr [logic [AW-1:0]];

   function automatic logic [DW-1:0] rdMem(input logic [AW-1:0] a);
      if (memArr.exists(a)) return memArr[a];
      return {a[15:0], 16'h5A3C} ^ 32'h1357_0000;
   endfunction

   function automatic logic [AW-1:0] randAddr();
      case ($urandom_range(3))
         0:       return 32'h0000_0008;
         1:       return 32'h0000_0064;
         default: return 32'($urandom) & 32'hFFFF_FFFC;
      endcase
   endfunction

   // Model: which stage owns the port (0 none, 1 fetch, 2 data) and what it must look like.
   int            busyWho = 0;
   bit            ackDone = 0;
   logic [AW-1:0] gAddr;
   logic [DW-1:0] gWdata, ackData;
   logic          gWe;
   logic [DW-1:0] expInstr = '0, expRead = '0;
   int            starve = 0;
   bit            fOwn = 0, dOwn = 0;
   int            mode = 0;
   int            pF, pD, ackPct, holdPct, scrPct;
   logic          prevReq = 1'b0;
   int            dutLog[$];

   task automatic predict(input bit rdyF, input bit rdyD);
      bit fElig, dElig;
      if (busyWho != 0) return;
      fElig = IReqF && !rdyF;
      dElig = DReqM && !rdyD;
      if (dElig && (!fElig || starve < SMAX)) begin
         busyWho = 2; gAddr = DataAdrM; gWe = MemWriteM; gWdata = WriteDataM;
         if (fElig && starve < SMAX) starve++;
      end else if (fElig) begin
         busyWho = 1; gAddr = PCF; gWe = 1'b0; starve = 0;
      end
   endtask

   task automatic driveReq(input bit rdyF, input bit rdyD);
      if (mode == 2) begin
         IReqF = 1'b0; DReqM = 1'b0; fOwn = 0; dOwn = 0;
      end else if (mode == 1) begin
         if (rdyF || rdyD) begin
            IReqF = 1'b0; DReqM = 1'b0;
         end else if (busyWho == 2) begin
            IReqF = 1'b0;
         end else if (busyWho == 1) begin
            DReqM = 1'b0;
         end else if (!IReqF && !DReqM) begin
            IReqF = 1'b1; PCF = 32'h0000_1000;
            DReqM = 1'b1; DataAdrM = 32'h0000_2000; MemWriteM = 1'b0;
         end
      end else begin
         if (rdyF) begin
            fOwn = 0; IReqF = ($urandom_range(99) < holdPct);
         end else if (!fOwn) begin
            if ($urandom_range(99) < pF) begin
               IReqF = 1'b1; PCF = randAddr(); fOwn = 1;
            end else IReqF = 1'b0;
         end else if (busyWho == 1) begin
            if ($urandom_range(99) < scrPct) PCF = $urandom;
            if ($urandom_range(7) == 0) IReqF = 1'b0;
         end
         if (rdyD) begin
            dOwn = 0; DReqM = ($urandom_range(99) < holdPct);
         end else if (!dOwn) begin
            if ($urandom_range(99) < pD) begin
               DReqM = 1'b1; DataAdrM = randAddr(); MemWriteM = 1'($urandom_range(1));
               WriteDataM = $urandom; dOwn = 1;
            end else DReqM = 1'b0;
         end else if (busyWho == 2) begin
            if ($urandom_range(99) < scrPct) begin
               DataAdrM = randAddr(); WriteDataM = $urandom; MemWriteM = ~MemWriteM;
            end
            if ($urandom_range(7) == 0) DReqM = 1'b0;
         end
      end
   endtask

   task automatic step();
      bit expIR, expDR;
      @(negedge clk);
      expIR = (busyWho == 1) && ackDone;
      expDR = (busyWho == 2) && ackDone;
      if (busyWho != 0 && !ackDone) begin
         checkEq("mem_req busy", 64'(mem_req), 64'h1);
         checkEq("mem_addr", 64'(mem_addr), 64'(gAddr));
         checkEq("mem_we", 64'(mem_we), 64'(gWe));
         if (busyWho == 2) checkEq("mem_wdata", 64'(mem_wdata), 64'(gWdata));
      end else begin
         checkEq("mem_req idle", 64'(mem_req), 64'h0);
         checkEq("mem_we idle", 64'(mem_we), 64'h0);
      end
      if (mem_req && !prevReq) dutLog.push_back((mem_addr == 32'h0000_2000) ? 2 : 1);
      prevReq = mem_req;
      if (expIR) expInstr = ackData;
      if (expDR && !gWe) expRead = ackData;
      checkEq("IRdyF", 64'(IRdyF), 64'(expIR));
      checkEq("DRdyM", 64'(DRdyM), 64'(expDR));
      checkEq("InstrF", 64'(InstrF), 64'(expInstr));
      checkEq("ReadDataM", 64'(ReadDataM), 64'(expRead));
      checkEq("StallF", 64'(StallF), 64'(IReqF && !expIR));
      checkEq("StallM", 64'(StallM), 64'(DReqM && !expDR));
      if (expIR || expDR) begin
         busyWho = 0; ackDone = 0;
      end
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      if (busyWho != 0) begin
         if ($urandom_range(99) < ackPct) begin
            mem_ack = 1'b1; ackDone = 1;
            if (gWe) memArr[gAddr] = gWdata;
            else mem_rdata = rdMem(gAddr);
            ackData = mem_rdata;
         end
      end else begin
         mem_ack = ($urandom_range(3) == 0);
      end
      driveReq(expIR, expDR);
      predict(expIR, expDR);
   endtask

   task automatic drain();
      mode = 2; ackPct = 60;
      for (int i = 0; i < 100; i++) begin
         step();
         if (busyWho == 0) break;
      end
      repeat (2) step();
   endtask

   task automatic resetValueChecks();
      checkEq("rst mem_req", 64'(mem_req), 64'h0);
      checkEq("rst mem_we", 64'(mem_we), 64'h0);
      checkEq("rst mem_addr", 64'(mem_addr), 64'h0);
      checkEq("rst mem_wdata", 64'(mem_wdata), 64'h0);
      checkEq("rst IRdyF", 64'(IRdyF), 64'h0);
      checkEq("rst DRdyM", 64'(DRdyM), 64'h0);
      checkEq("rst InstrF", 64'(InstrF), 64'h0);
      checkEq("rst ReadDataM", 64'(ReadDataM), 64'h0);
   endtask

   task automatic resetPhase();
      drain();
      DReqM = 1'b1; DataAdrM = 32'h0000_0064; MemWriteM = 1'b0; mem_ack = 1'b0;
      @(negedge clk);
      checkEq("grant before reset", 64'(mem_req), 64'h1);
      reset = 1'b1; mem_ack = 1'b0;
      @(negedge clk);
      resetValueChecks();
      reset = 1'b0; DReqM = 1'b0; IReqF = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      checkEq("post-rst DRdyM", 64'(DRdyM), 64'h0);
      checkEq("post-rst IRdyF", 64'(IRdyF), 64'h0);
      checkEq("post-rst ReadDataM", 64'(ReadDataM), 64'h0);
      checkEq("post-rst mem_req", 64'(mem_req), 64'h0);
      mem_ack = 1'b0;
      repeat (3) begin
         @(negedge clk);
         checkEq("quiet mem_req", 64'(mem_req), 64'h0);
      end
      busyWho = 0; ackDone = 0; expInstr = '0; expRead = '0; starve = 0;
      fOwn = 0; dOwn = 0; prevReq = 1'b0;
   endtask

   initial begin
      int expSeq[6];
      expSeq = '{2, 2, 2, 2, 1, 2};
      reset = 1'b1; IReqF = 1'b0; PCF = '0; DReqM = 1'b0; MemWriteM = 1'b0;
      DataAdrM = '0; WriteDataM = '0; mem_rdata = '0; mem_ack = 1'b0;
      memArr[32'h0000_0008] = 32'hE280_2005;
      repeat (2) @(negedge clk);
      resetValueChecks();

      // Lone fetch of 0x8 answered immediately.
      reset = 1'b0; IReqF = 1'b1; PCF = 32'h0000_0008; fOwn = 1;
      mode = 0; pF = 0; pD = 0; ackPct = 100; holdPct = 0; scrPct = 0;
      predict(1'b0, 1'b0);
      repeat (4) step();
      checkEq("fetch 0x8 InstrF", 64'(InstrF), 64'hE280_2005);

      mode = 0; pF = 30; pD = 30; ackPct = 40; holdPct = 30; scrPct = 50;
      repeat (1500) step();

      resetPhase();

      // Both stages present together after a quiet cycle; fetch withdraws while data is served.
      mode = 1; ackPct = 50; dutLog.delete();
      for (int i = 0; i < 400 && dutLog.size() < 6; i++) step();
      for (int i = 0; i < 6; i++)
         checkEq($sformatf("grant seq %0d", i), 64'((i < dutLog.size()) ? dutLog[i] : 0), 64'(expSeq[i]));
      drain();

      mode = 0; pF = 60; pD = 60; ackPct = 90; holdPct = 70; scrPct = 80;
      repeat (1000) step();
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", chkCnt, errCnt);
      $finish;
   end

endmodule
